// File: rtl/wb_periph_xbar_ctrl.sv
`default_nettype none
// ============================================================================
// wb_periph_xbar_ctrl - single-master Wishbone fan-out to NS peripheral slaves
// Optional hung-slave abort: WB_BUS_TIMEOUT_EN.          Rev 1.0
// ============================================================================
module wb_periph_xbar_ctrl #(
  parameter int unsigned NS          = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SLV_SHIFT   = 16,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [NS-1:0]  s_cyc_o,
  output logic [NS-1:0]  s_stb_o,
  output logic           s_we_o,
  output logic [3:0]     s_sel_o,
  output logic [31:0]    s_adr_o,
  output logic [31:0]    s_dat_o,
  input  logic [NS-1:0]  s_ack_i,
  input  logic [NS*32-1:0] s_dat_i,
  output logic           bus_err_o
);

  localparam int unsigned IW     = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned PAD_LO = SLV_SHIFT + IW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NS-1:0] cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   resp_q, resp_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          err_q, err_d;

  logic [IW-1:0] req_idx;
  logic          hit;
  logic          sel_ack;
  logic          tmo_hit;
  logic [31:0]   s_rd [NS];

  for (genvar k = 0; k < NS; k++) begin : g_slice
    assign s_rd[k] = s_dat_i[32*k +: 32];
  end

  assign req_idx = wbs_adr_i[SLV_SHIFT +: IW];
  assign sel_ack = s_ack_i[idx_q];

  always_comb begin
    hit = 1'b0;
    if ((wbs_adr_i[31:24] == BASE_ADDR[31:24]) &&
        (wbs_adr_i[23:PAD_LO] == '0) &&
        (32'(req_idx) < NS))
      hit = 1'b1;
  end

`ifdef WB_BUS_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CW-1:0] tmo_q, tmo_d;

  // Firing on TIMEOUT_CYC-1 means the abort lands after exactly TIMEOUT_CYC busy cycles.
  assign tmo_hit = (32'(tmo_q) == TIMEOUT_CYC - 1);

  always_comb begin
    tmo_d = '0;
    if (state_q == S_BUSY && !sel_ack)
      tmo_d = tmo_q + CW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    resp_d  = resp_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    rdat_d  = '0;
    case (state_q)
      S_IDLE: begin
        // ack_q high means the host is still holding stb from the finished cycle.
        if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
          we_d  = wbs_we_i;
          sel_d = wbs_sel_i;
          adr_d = wbs_adr_i;
          dat_d = wbs_dat_i;
          idx_d = req_idx;
          if (hit) begin
            state_d = S_BUSY;
            cyc_d   = NS'(1) << req_idx;
          end else begin
            state_d = S_RESP;
            resp_d  = ERR_DATA;
            err_d   = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (!wbs_cyc_i) begin
          cyc_d   = '0;
          state_d = S_IDLE;
        end else if (sel_ack) begin
          resp_d  = s_rd[idx_q];
          cyc_d   = '0;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          resp_d  = ERR_DATA;
          err_d   = 1'b1;
          cyc_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ack_d   = 1'b1;
        rdat_d  = resp_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      resp_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      resp_q  <= resp_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_cyc_o   = cyc_q;
  assign s_stb_o   = cyc_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = dat_q;
  assign bus_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_periph_xbar_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wb_periph_xbar_ctrl - directed self-checking bench for wb_periph_xbar_ctrl
// Rev 1.0
// ============================================================================
module tb_wb_periph_xbar_ctrl;

  localparam int unsigned NS = 4;

  logic            clk;
  logic            rst;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic [NS-1:0]   s_cyc, s_stb;
  logic            s_we;
  logic [3:0]      s_sel;
  logic [31:0]     s_adr, s_dat;
  logic [NS-1:0]   s_ack;
  logic [NS*32-1:0] s_rd;
  logic            berr;

  int n_checks = 0;
  int n_pass   = 0;

  wb_periph_xbar_ctrl #(
    .NS(NS), .BASE_ADDR(32'h3000_0000), .SLV_SHIFT(16),
    .TIMEOUT_CYC(16), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat),
    .s_ack_i(s_ack), .s_dat_i(s_rd),
    .bus_err_o(berr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
  endtask

  task automatic host_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},  {31'd0, ack}, 32'd0);
    check({tag, "_rdat"}, rdat, 32'd0);
    check({tag, "_cyc"},  {28'd0, s_cyc}, 32'd0);
    check({tag, "_stb"},  {28'd0, s_stb}, 32'd0);
    check({tag, "_we"},   {31'd0, s_we}, 32'd0);
    check({tag, "_sel"},  {28'd0, s_sel}, 32'd0);
    check({tag, "_adr"},  s_adr, 32'd0);
    check({tag, "_sdat"}, s_dat, 32'd0);
    check({tag, "_err"},  {31'd0, berr}, 32'd0);
  endtask

  initial begin
    int ack_seen;
    rst = 1'b1; s_ack = '0; s_rd = '0; sel = '0; adr = '0; wdat = '0;
    host_idle();
    tick(); tick();
    check_reset_outputs("rst0");
    rst = 1'b0;
    tick();

    // Write to slave1, ack in first strobe cycle
    host_req(1'b1, 32'h3001_0004, 32'h0000_00A5);
    tick();                                   // edge 0
    check("wr_cyc",  {28'd0, s_cyc}, 32'h2);
    check("wr_stb",  {28'd0, s_stb}, 32'h2);
    check("wr_adr",  s_adr, 32'h3001_0004);
    check("wr_sdat", s_dat, 32'h0000_00A5);
    check("wr_we",   {31'd0, s_we}, 32'd1);
    check("wr_sel",  {28'd0, s_sel}, 32'hF);
    check("wr_ack0", {31'd0, ack}, 32'd0);
    s_ack = 4'b0010; s_rd[32 +: 32] = 32'hCAFE_0001;
    tick();                                   // edge 1
    check("wr_cyc_clr", {28'd0, s_cyc}, 32'd0);
    check("wr_ack1", {31'd0, ack}, 32'd0);
    s_ack = '0;
    tick();                                   // edge 2
    check("wr_ack2", {31'd0, ack}, 32'd1);
    check("wr_rdat", rdat, 32'hCAFE_0001);
    tick();                                   // stb still high: no duplicate
    check("wr_ack3", {31'd0, ack}, 32'd0);
    check("wr_rdat3", rdat, 32'd0);
    check("wr_nodup", {28'd0, s_cyc}, 32'd0);
    host_idle();
    tick();
    check("wr_nodup2", {28'd0, s_cyc}, 32'd0);
    check("wr_err", {31'd0, berr}, 32'd0);

    // Read slave3 with three wait cycles
    host_req(1'b0, 32'h3003_0000, 32'd0);
    s_rd[96 +: 32] = 32'h1234_5678;
    tick();
    check("rd3_cyc", {28'd0, s_cyc}, 32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd3_wait_cyc", {28'd0, s_cyc}, 32'h8);
      check("rd3_wait_dat", rdat, 32'd0);
    end
    s_ack = 4'b1000;
    tick();
    check("rd3_ack_early", {31'd0, ack}, 32'd0);
    s_ack = '0;
    tick();
    check("rd3_ack", {31'd0, ack}, 32'd1);
    check("rd3_rdat", rdat, 32'h1234_5678);
    host_idle();
    tick();
    check("rd3_ack_off", {31'd0, ack}, 32'd0);
    check("rd3_rdat_off", rdat, 32'd0);
    check("rd3_err", {31'd0, berr}, 32'd0);

    // Decode errors: index out of window, then wrong base
    host_req(1'b0, 32'h3004_0000, 32'd0);
    tick();
    check("de1_cyc", {28'd0, s_cyc}, 32'd0);
    check("de1_ack0", {31'd0, ack}, 32'd0);
    tick();
    check("de1_ack", {31'd0, ack}, 32'd1);
    check("de1_rdat", rdat, 32'hDEAD_BEEF);
    check("de1_err", {31'd0, berr}, 32'd1);
    host_idle();
    tick();
    host_req(1'b0, 32'h4000_0000, 32'd0);
    tick();
    check("de2_cyc", {28'd0, s_cyc}, 32'd0);
    tick();
    check("de2_ack", {31'd0, ack}, 32'd1);
    check("de2_rdat", rdat, 32'hDEAD_BEEF);
    host_idle();
    tick();
    check("de2_err_sticky", {31'd0, berr}, 32'd1);

    // Slave2 read with stray acks from slaves 0 and 1
    host_req(1'b0, 32'h3002_0000, 32'd0);
    s_rd[0 +: 32] = 32'h1111_1111; s_rd[64 +: 32] = 32'hA2A2_0002;
    tick();
    check("st_cyc", {28'd0, s_cyc}, 32'h4);
    s_ack = 4'b0011;
    tick();
    check("st_hold1", {28'd0, s_cyc}, 32'h4);
    tick();
    check("st_hold2", {28'd0, s_cyc}, 32'h4);
    check("st_noack", {31'd0, ack}, 32'd0);
    s_ack = 4'b0111;
    tick();
    check("st_cyc_clr", {28'd0, s_cyc}, 32'd0);
    s_ack = '0;
    tick();
    check("st_ack", {31'd0, ack}, 32'd1);
    check("st_rdat", rdat, 32'hA2A2_0002);
    host_idle();
    tick();

    // Host abort in second busy cycle
    host_req(1'b0, 32'h3000_0008, 32'd0);
    tick();
    check("ab_cyc", {28'd0, s_cyc}, 32'h1);
    tick();
    host_idle();
    tick();
    check("ab_cyc_clr", {28'd0, s_cyc}, 32'd0);
    check("ab_noack", {31'd0, ack}, 32'd0);
    tick();
    check("ab_noack2", {31'd0, ack}, 32'd0);

    // Reset mid-transaction
    host_req(1'b1, 32'h3001_0010, 32'h0000_0055);
    tick();
    check("mr_cyc", {28'd0, s_cyc}, 32'h2);
    rst = 1'b1;
    host_idle();
    tick();
    check_reset_outputs("mr");
    rst = 1'b0;
    tick();
    check("mr_noack", {31'd0, ack}, 32'd0);

    // Hung slave
    host_req(1'b0, 32'h3001_0000, 32'd0);
    tick();
`ifdef WB_BUS_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("to_cyc_hold", {28'd0, s_cyc}, 32'h2);
    tick();
    check("to_cyc_clr", {28'd0, s_cyc}, 32'd0);
    check("to_ack0", {31'd0, ack}, 32'd0);
    tick();
    check("to_ack", {31'd0, ack}, 32'd1);
    check("to_rdat", rdat, 32'hDEAD_BEEF);
    check("to_err", {31'd0, berr}, 32'd1);
    host_idle();
    tick();
`else
    ack_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (ack) ack_seen++;
    end
    check("hang_noack", ack_seen, 0);
    check("hang_cyc", {28'd0, s_cyc}, 32'h2);
    check("hang_err", {31'd0, berr}, 32'd0);
    host_idle();
    tick();
    check("hang_abort", {28'd0, s_cyc}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_periph_xbar_ctrl.md
Name: wb_periph_xbar_ctrl

Overview:
Single-master Wishbone controller that shares the user-area Wishbone slave port among NS peripheral slaves (SPI0, SPI1, I2C, GPIO in the current SoC). It decodes the address, sequences one transaction at a time to the selected peripheral, and returns a registered ack and data to the management SoC. Undecoded addresses and, optionally, hung slaves get an error response and set a sticky error flag. It sits between the user_project Wishbone inputs and the peripheral blocks.

Parameters:
NS, 4, number of downstream slaves (2..8); IW = clog2(NS) index bits
BASE_ADDR, 32'h3000_0000, user-area base; only bits [31:24] are compared
SLV_SHIFT, 16, LSB of the slave index field (64 KB window per slave)
TIMEOUT_CYC, 255, BUSY cycles without ack before abort (used only with the optional feature)
ERR_DATA, 32'hDEAD_BEEF, read data returned on any error response

Ports:
wb_clk_i  in  1  the single clock
wb_rst_i  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  host cycle
wbs_stb_i  in  1  host strobe
wbs_we_i  in  1  host write enable
wbs_sel_i  in  4  host byte selects
wbs_adr_i  in  32  host address
wbs_dat_i  in  32  host write data
wbs_ack_o  out  1  registered one-cycle ack to host
wbs_dat_o  out  32  read data to host, valid with ack
s_cyc_o  out  NS  per-slave cycle, one-hot or zero
s_stb_o  out  NS  per-slave strobe, equal to s_cyc_o
s_we_o  out  1  shared latched write enable
s_sel_o  out  4  shared latched byte selects
s_adr_o  out  32  shared latched full address
s_dat_o  out  32  shared latched write data
s_ack_i  in  NS  per-slave ack
s_dat_i  in  NS*32  per-slave read data; slave k drives bits [32k+31:32k]
bus_err_o  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a rising edge): state IDLE; wbs_ack_o=0, wbs_dat_o=0, s_cyc_o=s_stb_o=0, s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0, bus_err_o=0, timeout counter=0. Reset during BUSY drops downstream cyc/stb on the same edge, and no ack is issued.
- Decode of wbs_adr_i: hit iff adr[31:24]==BASE_ADDR[31:24], adr[23:SLV_SHIFT+IW]==0 and idx=adr[SLV_SHIFT+IW-1:SLV_SHIFT] < NS. Anything else is a decode error.
- FSM states: IDLE, BUSY, RESP.
- IDLE: on wbs_cyc_i & wbs_stb_i, latch we/sel/adr/dat and idx.
  - Hit: go to BUSY and assert s_cyc_o[idx]=s_stb_o[idx]=1 from the next cycle.
  - Error: go to RESP with data ERR_DATA and set bus_err_o.
- BUSY: downstream signals stay stable. Only s_ack_i[idx] is honoured; acks from other slaves are ignored.
  - On s_ack_i[idx]: capture the slave's s_dat_i slice, clear s_cyc_o/s_stb_o on the same edge, go to RESP.
  - If wbs_cyc_i drops: clear downstream signals, go to IDLE, no ack.
- RESP: wbs_ack_o=1 for exactly one cycle with wbs_dat_o = captured data (write cycles return the captured slice). Then go to IDLE.
- wbs_dat_o is 0 in every cycle where wbs_ack_o=0.
- Latency: host strobe sampled at edge 0; downstream stb visible after edge 0; a slave acking in its first stb cycle gives wbs_ack_o after edge 2. Decode error gives wbs_ack_o after edge 1.
- One outstanding transaction only. Host strobes seen in BUSY or RESP are not re-latched. The host is required to drop stb after seeing ack, so the IDLE cycle after RESP must not start a duplicate transaction.

Optional Feature:
Macro WB_BUS_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT_CYC, clear downstream cyc/stb, set bus_err_o, go to RESP with ERR_DATA. If the ack arrives in the same cycle the count hits TIMEOUT_CYC, the ack wins (normal response, no error).
- Undefined: no counter; BUSY waits indefinitely; bus_err_o is set only by decode errors.

Test Plan:
- Write 0x3001_0004 data 0x0000_00A5 sel 4'hF; slave1 acks in its first stb cycle -> s_cyc_o=4'b0010, s_adr_o=0x3001_0004, s_dat_o=0xA5, s_we_o=1; wbs_ack_o high one cycle, 2 cycles after host stb.
- Read 0x3003_0000; slave3 acks after 3 wait cycles with 0x1234_5678 -> wbs_dat_o=0x1234_5678 with ack, 0 otherwise; bus_err_o stays 0.
- Read 0x3004_0000 and 0x4000_0000 -> no s_cyc_o, ack after 1 cycle, wbs_dat_o=0xDEAD_BEEF, bus_err_o=1 and stays 1 until reset.
- Read slave2 while slave0 and slave1 assert s_ack_i -> stray acks ignored; transaction completes only on s_ack_i[2].
- Host drops wbs_cyc_i in the 2nd BUSY cycle, then wb_rst_i pulsed mid-transaction on a second access -> downstream cleared, no wbs_ack_o, all outputs at reset values.
- With WB_BUS_TIMEOUT_EN and TIMEOUT_CYC=16, slave never acks -> after 16 BUSY cycles cyc cleared, ack with 0xDEAD_BEEF, bus_err_o=1. Without the macro -> no ack after 1000 cycles.
